sad_trigger_qualifier: RTL and testbench

- Sits directly downstream of the SAD matcher in the clk_adc domain.
- Consumes the raw SAD match output and turns it into a qualified scope trigger. Qualification covers Nth-match selection, a programmable pulse width and a post-trigger holdoff.
- Gives firmware a clean, single, well-defined trigger per arm cycle, plus match statistics.

---
 rtl/sad_trigger_qualifier_pkg.sv | 19 +
 rtl/sad_trigger_qualifier_edge_detect.sv | 21 ++
 rtl/sad_trigger_qualifier.sv | 173 +++++++++++++++++
 tb/tb_sad_trigger_qualifier.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/sad_trigger_qualifier_pkg.sv
// Shared definitions for the SAD trigger qualifier: state encoding and a
// saturating increment helper used by the match and miss counters.
package sad_trigger_qualifier_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_WAIT    = 2'd1;
    localparam state_t ST_PULSE   = 2'd2;
    localparam state_t ST_HOLDOFF = 2'd3;

    // Increment val, holding at the all-ones value of a 'bits'-wide counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned bits);
        logic [31:0] max_val;
        max_val = (bits >= 32) ? 32'hFFFF_FFFF : ((32'd1 << bits) - 32'd1);
        return (val >= max_val) ? max_val : (val + 32'd1);
    endfunction

endpackage

// File: rtl/sad_trigger_qualifier_edge_detect.sv
// Registered rising-edge detector: rise is high in the cycle din goes 0->1.
module sad_edge_detect (
    input  logic clk_adc,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic din_q;

    always_ff @(posedge clk_adc) begin
        if (reset) begin
            din_q <= 1'b0;
        end else begin
            din_q <= din;
        end
    end

    assign rise = din & ~din_q;

endmodule

// File: rtl/sad_trigger_qualifier.sv
// Qualifies raw SAD matches into one scope trigger per arm: Nth-match select,
// programmable pulse width and holdoff. Define SAD_TRIG_MISS_CNT_EN for missed_count.
module sad_trigger_qualifier
    import sad_trigger_qualifier_pkg::*;
#(
    parameter int pCOUNT_BITS   = 16,
    parameter int pPULSE_BITS   = 8,
    parameter int pHOLDOFF_BITS = 16
) (
    input  logic                     clk_adc,
    input  logic                     reset,
    input  logic                     armed_and_ready,
    input  logic                     sad_trigger_in,
    input  logic [pCOUNT_BITS-1:0]   trig_num,
    input  logic [pPULSE_BITS-1:0]   pulse_cycles,
    input  logic [pHOLDOFF_BITS-1:0] holdoff_cycles,
    output logic                     trigger,
    output logic                     busy,
    output logic                     fired,
    output logic [pCOUNT_BITS-1:0]   match_count
`ifdef SAD_TRIG_MISS_CNT_EN
    ,
    output logic [pCOUNT_BITS-1:0]   missed_count
`endif
);

    logic arm_rise;
    logic match_rise;

    sad_edge_detect u_arm_edge (
        .clk_adc (clk_adc),
        .reset   (reset),
        .din     (armed_and_ready),
        .rise    (arm_rise)
    );

    sad_edge_detect u_match_edge (
        .clk_adc (clk_adc),
        .reset   (reset),
        .din     (sad_trigger_in),
        .rise    (match_rise)
    );

    state_t                   state_q, state_d;
    logic [pCOUNT_BITS-1:0]   match_count_q, match_count_d;
    logic                     fired_q, fired_d;
    logic                     trigger_q, trigger_d;
    logic [pPULSE_BITS-1:0]   pulse_cnt_q, pulse_cnt_d;
    logic [pHOLDOFF_BITS-1:0] holdoff_cnt_q, holdoff_cnt_d;
    logic [pCOUNT_BITS-1:0]   trig_num_q, trig_num_d;
    logic [pPULSE_BITS-1:0]   pulse_len_q, pulse_len_d;
    logic [pHOLDOFF_BITS-1:0] holdoff_len_q, holdoff_len_d;

    // Compare with one extra bit so a saturated counter can never match.
    logic [pCOUNT_BITS:0] count_plus1;
    logic                 fire_hit;

    assign count_plus1 = {1'b0, match_count_q} + {{pCOUNT_BITS{1'b0}}, 1'b1};
    assign fire_hit    = (count_plus1 == {1'b0, trig_num_q});

    always_ff @(posedge clk_adc) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            match_count_q <= '0;
            fired_q       <= 1'b0;
            trigger_q     <= 1'b0;
            pulse_cnt_q   <= '0;
            holdoff_cnt_q <= '0;
            trig_num_q    <= '0;
            pulse_len_q   <= '0;
            holdoff_len_q <= '0;
        end else begin
            state_q       <= state_d;
            match_count_q <= match_count_d;
            fired_q       <= fired_d;
            trigger_q     <= trigger_d;
            pulse_cnt_q   <= pulse_cnt_d;
            holdoff_cnt_q <= holdoff_cnt_d;
            trig_num_q    <= trig_num_d;
            pulse_len_q   <= pulse_len_d;
            holdoff_len_q <= holdoff_len_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        match_count_d = match_count_q;
        fired_d       = fired_q;
        trigger_d     = trigger_q;
        pulse_cnt_d   = pulse_cnt_q;
        holdoff_cnt_d = holdoff_cnt_q;
        trig_num_d    = trig_num_q;
        pulse_len_d   = pulse_len_q;
        holdoff_len_d = holdoff_len_q;
        case (state_q)
            ST_IDLE: begin
                if (arm_rise) begin
                    state_d       = ST_WAIT;
                    match_count_d = '0;
                    fired_d       = 1'b0;
                    trig_num_d    = (trig_num == '0) ? pCOUNT_BITS'(1) : trig_num;
                    pulse_len_d   = (pulse_cycles == '0) ? pPULSE_BITS'(1) : pulse_cycles;
                    holdoff_len_d = holdoff_cycles;
                end
            end
            ST_WAIT: begin
                if (!armed_and_ready) begin
                    state_d = ST_IDLE;
                end else if (match_rise) begin
                    match_count_d = pCOUNT_BITS'(sat_inc(32'(match_count_q), pCOUNT_BITS));
                    if (fire_hit) begin
                        state_d     = ST_PULSE;
                        trigger_d   = 1'b1;
                        fired_d     = 1'b1;
                        pulse_cnt_d = pulse_len_q;
                    end
                end
            end
            ST_PULSE: begin
                if (pulse_cnt_q <= pPULSE_BITS'(1)) begin
                    trigger_d = 1'b0;
                    if (holdoff_len_q != '0) begin
                        state_d       = ST_HOLDOFF;
                        holdoff_cnt_d = holdoff_len_q;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    pulse_cnt_d = pulse_cnt_q - pPULSE_BITS'(1);
                end
            end
            ST_HOLDOFF: begin
                if (holdoff_cnt_q <= pHOLDOFF_BITS'(1)) begin
                    state_d = ST_IDLE;
                end else begin
                    holdoff_cnt_d = holdoff_cnt_q - pHOLDOFF_BITS'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        trigger     = trigger_q;
        busy        = (state_q != ST_IDLE);
        fired       = fired_q;
        match_count = match_count_q;
    end

`ifdef SAD_TRIG_MISS_CNT_EN
    logic [pCOUNT_BITS-1:0] missed_count_q, missed_count_d;

    always_ff @(posedge clk_adc) begin
        if (reset) begin
            missed_count_q <= '0;
        end else begin
            missed_count_q <= missed_count_d;
        end
    end

    always_comb begin
        missed_count_d = missed_count_q;
        if (state_q == ST_IDLE && arm_rise) begin
            missed_count_d = '0;
        end else if ((state_q == ST_PULSE || state_q == ST_HOLDOFF) && match_rise) begin
            missed_count_d = pCOUNT_BITS'(sat_inc(32'(missed_count_q), pCOUNT_BITS));
        end
    end

    assign missed_count = missed_count_q;
`endif

endmodule

// File: tb/tb_sad_trigger_qualifier.sv
// Directed bench for sad_trigger_qualifier; expected trigger pulses are queued
// when a match is driven and checked by a monitor as the DUT emits them.
module tb_sad_trigger_qualifier;

    logic        clk_adc = 1'b0;
    logic        reset;
    logic        armed_and_ready;
    logic        sad_trigger_in;
    logic [15:0] trig_num;
    logic [7:0]  pulse_cycles;
    logic [15:0] holdoff_cycles;
    logic        trigger;
    logic        busy;
    logic        fired;
    logic [15:0] match_count;
`ifdef SAD_TRIG_MISS_CNT_EN
    logic [15:0] missed_count;
`endif

    sad_trigger_qualifier dut (
        .clk_adc         (clk_adc),
        .reset           (reset),
        .armed_and_ready (armed_and_ready),
        .sad_trigger_in  (sad_trigger_in),
        .trig_num        (trig_num),
        .pulse_cycles    (pulse_cycles),
        .holdoff_cycles  (holdoff_cycles),
        .trigger         (trigger),
        .busy            (busy),
        .fired           (fired),
        .match_count     (match_count)
`ifdef SAD_TRIG_MISS_CNT_EN
        ,
        .missed_count    (missed_count)
`endif
    );

    always #5 clk_adc = ~clk_adc;

    typedef struct {
        int start;
        int width;
        bit idle_after;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rise_cyc = 0;
    bit   active = 1'b0;
    logic trig_prev = 1'b0;

    always @(posedge clk_adc) cyc++;

    // Scoreboard monitor: each trigger pulse must match the head of exp_q.
    always @(negedge clk_adc) begin
        if (trigger === 1'b1 && trig_prev !== 1'b1) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_trigger observed=rise@%0d expected=none", cyc);
            end
            if (exp_q.size() != 0) begin
                cur = exp_q.pop_front();
                rise_cyc = cyc;
                active = 1'b1;
                checks++;
                assert (cyc === cur.start) else begin
                    errors++;
                    $error("FAIL trigger_start observed=%0d expected=%0d", cyc, cur.start);
                end
            end
        end
        if (trigger === 1'b0 && trig_prev === 1'b1 && active) begin
            active = 1'b0;
            checks++;
            assert ((cyc - rise_cyc) === cur.width) else begin
                errors++;
                $error("FAIL trigger_width observed=%0d expected=%0d", cyc - rise_cyc, cur.width);
            end
            checks++;
            assert (busy === !cur.idle_after) else begin
                errors++;
                $error("FAIL busy_at_pulse_end observed=%0b expected=%0b", busy, !cur.idle_after);
            end
        end
        trig_prev = trigger;
    end

    task automatic tick();
        @(posedge clk_adc);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic arm(input int tn, input int pc, input int ho);
        armed_and_ready = 1'b0;
        tick();
        trig_num       = 16'(tn);
        pulse_cycles   = 8'(pc);
        holdoff_cycles = 16'(ho);
        armed_and_ready = 1'b1;
        tick();
        $display("arm trig_num=%0d pulse=%0d holdoff=%0d", tn, pc, ho);
        chk("busy_after_arm", 32'(busy), 32'd1);
    endtask

    // One match pulse (high one cycle, then low one cycle).
    task automatic match(input bit fire, input int width, input bit idle_after);
        if (fire) exp_q.push_back('{cyc + 1, width, idle_after});
        $display("match cycle=%0d expect_fire=%0b", cyc + 1, fire);
        sad_trigger_in = 1'b1;
        tick();
        sad_trigger_in = 1'b0;
        tick();
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy !== 1'b0 || exp_q.size() != 0 || active) && n < budget) begin
            tick();
            n++;
        end
        chk("wait_idle_timeout", 32'(n < budget), 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        armed_and_ready = 1'b0;
        sad_trigger_in = 1'b0;
        trig_num = '0;
        pulse_cycles = '0;
        holdoff_cycles = '0;
        repeat (3) tick();
        chk("reset_trigger", 32'(trigger), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_fired", 32'(fired), 32'd0);
        chk("reset_match_count", 32'(match_count), 32'd0);
        reset = 1'b0;
        tick();

        // First match fires, 4-cycle pulse, no holdoff.
        arm(1, 4, 0);
        repeat (5) tick();
        match(1'b1, 4, 1'b1);
        wait_idle(50);
        chk("t1_fired", 32'(fired), 32'd1);
        chk("t1_match_count", 32'(match_count), 32'd1);

        // Third match fires; config change after arm must be ignored.
        arm(3, 2, 0);
        trig_num = 16'd1;
        match(1'b0, 0, 1'b0);
        repeat (4) tick();
        match(1'b0, 0, 1'b0);
        chk("t2_count_before", 32'(match_count), 32'd2);
        chk("t2_fired_before", 32'(fired), 32'd0);
        repeat (4) tick();
        match(1'b1, 2, 1'b1);
        wait_idle(50);
        chk("t2_match_count", 32'(match_count), 32'd3);
        chk("t2_fired", 32'(fired), 32'd1);

        // Matches during pulse and holdoff are ignored.
        arm(1, 2, 8);
        match(1'b1, 2, 1'b0);
        match(1'b0, 0, 1'b0);
        match(1'b0, 0, 1'b0);
        match(1'b0, 0, 1'b0);
        chk("t3_busy_holdoff", 32'(busy), 32'd1);
        chk("t3_match_count", 32'(match_count), 32'd1);
`ifdef SAD_TRIG_MISS_CNT_EN
        chk("t3_missed_count", 32'(missed_count), 32'd3);
`endif
        wait_idle(50);
        match(1'b0, 0, 1'b0);
        chk("t3_no_rearm_count", 32'(match_count), 32'd1);
        chk("t3_no_rearm_busy", 32'(busy), 32'd0);

        // Disarm on the same cycle as the firing match.
        arm(3, 4, 0);
        match(1'b0, 0, 1'b0);
        match(1'b0, 0, 1'b0);
        armed_and_ready = 1'b0;
        sad_trigger_in = 1'b1;
        tick();
        sad_trigger_in = 1'b0;
        tick();
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_match_count", 32'(match_count), 32'd2);
        chk("t4_fired", 32'(fired), 32'd0);

        // Reset in the middle of a pulse truncates it.
        arm(1, 4, 0);
        match(1'b1, 2, 1'b1);
        reset = 1'b1;
        armed_and_ready = 1'b0;
        tick();
        chk("t5_trigger", 32'(trigger), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_fired", 32'(fired), 32'd0);
        chk("t5_match_count", 32'(match_count), 32'd0);
        reset = 1'b0;
        tick();
        match(1'b0, 0, 1'b0);
        repeat (3) tick();
        chk("t5_post_busy", 32'(busy), 32'd0);
        chk("t5_post_count", 32'(match_count), 32'd0);

        // Zero trig_num and pulse_cycles behave as 1; level arm does not re-arm.
        arm(0, 0, 0);
        match(1'b1, 1, 1'b1);
        wait_idle(50);
        match(1'b0, 0, 1'b0);
        repeat (3) tick();
        chk("t6_match_count", 32'(match_count), 32'd1);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_fired", 32'(fired), 32'd1);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
